// File: rtl/mem_access_responder_pkg.sv
// Shared types for the memory-side responder of the cache memory-access protocol.
// Line geometry and MSHR count live here so the cache side and the responder always agree.
package mem_access_responder_pkg;

    localparam int MSHR_NUM                       = 2;
    localparam int PHY_ADDR_WIDTH                 = 32;
    localparam int DCACHE_LINE_BIT_WIDTH          = 64;
    localparam int DCACHE_LINE_BYTE_NUM_BIT_WIDTH = 3;
    localparam int MEM_ACCESS_SERIAL_BIT_SIZE     = $clog2(MSHR_NUM + 1);
    localparam int MEM_WRITE_SERIAL_BIT_SIZE      = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;
    localparam int OUTSTANDING_BIT_WIDTH          = $clog2(MSHR_NUM + 2);

    typedef logic [PHY_ADDR_WIDTH-1:0]             PhyAddrPath;
    typedef logic [DCACHE_LINE_BIT_WIDTH-1:0]      DCacheLinePath;
    typedef logic [MEM_ACCESS_SERIAL_BIT_SIZE-1:0] MemAccessSerial;
    typedef logic [MEM_WRITE_SERIAL_BIT_SIZE-1:0]  MemWriteSerial;
    typedef logic [OUTSTANDING_BIT_WIDTH-1:0]      OutstandingCount;

    // valid/ack handshake: a request is taken in the same cycle that ack is high;
    // completions are single-cycle pulses with no backpressure.
    typedef struct packed {
        logic          valid;
        logic          we;
        PhyAddrPath    addr;
        DCacheLinePath data;
    } MemAccessReq;

    typedef struct packed {
        logic           ack;
        MemAccessSerial serial;
        MemWriteSerial  wserial;
    } MemAccessReqAck;

    typedef struct packed {
        logic           valid;
        MemAccessSerial serial;
        DCacheLinePath  data;
    } MemAccessResult;

    typedef struct packed {
        logic          valid;
        MemWriteSerial serial;
    } MemAccessResponse;

    typedef enum logic [1:0] {
        MRS_IDLE,
        MRS_WAIT,
        MRS_RESPOND
    } MemResponderState;

    typedef struct packed {
        logic           we;
        PhyAddrPath     addr;
        DCacheLinePath  data;
        MemAccessSerial serial;
        MemWriteSerial  wserial;
    } MemResponderEntry;

    function automatic MemAccessSerial next_rd_serial(input MemAccessSerial s);
        return (s == MemAccessSerial'(MSHR_NUM)) ? '0 : s + MemAccessSerial'(1);
    endfunction

    function automatic MemWriteSerial next_wr_serial(input MemWriteSerial s);
        return (s == MemWriteSerial'(MSHR_NUM - 1)) ? '0 : s + MemWriteSerial'(1);
    endfunction

endpackage

// File: rtl/mem_access_responder_line_ram.sv
// Line-wide backing store: one write port, one registered read port.
// Contents are never reset; a read returns data one cycle after re is sampled.
module mem_access_line_ram #(
    parameter int INDEX_W = 12,
    parameter int DATA_W  = 64
) (
    input  logic               clk,
    input  logic               we,
    input  logic [INDEX_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               re,
    input  logic [INDEX_W-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem_q [2**INDEX_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_responder.sv
// In-order memory responder: request FIFO, read/write serial allocation and a
// fixed-latency IDLE/WAIT/RESPOND service FSM in front of a line RAM.
module mem_access_responder
    import mem_access_responder_pkg::*;
#(
    parameter int MEM_LATENCY         = 4,
    parameter int QUEUE_DEPTH         = 4,
    parameter int MEM_INDEX_BIT_WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  MemAccessReq      memAccessReq,
    output MemAccessReqAck   memAccessReqAck,
    output MemAccessResult   memAccessResult,
    output MemAccessResponse memAccessResponse
);

    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int LAT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int ADDR_LO = DCACHE_LINE_BYTE_NUM_BIT_WIDTH;
    localparam int ADDR_HI = ADDR_LO + MEM_INDEX_BIT_WIDTH;

    typedef logic [PTR_W:0]               ptr_t;
    typedef logic [LAT_W-1:0]             lat_t;
    typedef logic [MEM_INDEX_BIT_WIDTH-1:0] index_t;

    MemResponderEntry fifo_q [QUEUE_DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    MemResponderState state_q, state_d;
    lat_t             lat_cnt_q, lat_cnt_d;
    MemResponderEntry svc_q, svc_d;
    OutstandingCount  rd_out_q, rd_out_d, wr_out_q, wr_out_d;
    MemAccessSerial   rd_serial_q, rd_serial_d;
    MemWriteSerial    wr_serial_q, wr_serial_d;

    logic             fifo_full, fifo_empty, push, pop;
    logic             ram_we, ram_re, rd_done, wr_done;
    MemResponderEntry push_entry;
    index_t           ram_index;
    DCacheLinePath    ram_rdata;
    logic             unused_addr_bits;

    // Accept path uses pre-dequeue FIFO state, so a pop never frees a slot in the same cycle.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                     (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
        push = memAccessReq.valid && !fifo_full &&
               (memAccessReq.we ? (wr_out_q < OutstandingCount'(MSHR_NUM))
                                : (rd_out_q < OutstandingCount'(MSHR_NUM + 1)));

        push_entry         = '0;
        push_entry.we      = memAccessReq.we;
        push_entry.addr    = memAccessReq.addr;
        push_entry.data    = memAccessReq.data;
        memAccessReqAck     = '0;
        memAccessReqAck.ack = push;
        if (push) begin
            if (memAccessReq.we) begin
                push_entry.wserial      = wr_serial_q;
                memAccessReqAck.wserial = wr_serial_q;
            end else begin
                push_entry.serial      = rd_serial_q;
                memAccessReqAck.serial = rd_serial_q;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        lat_cnt_d         = lat_cnt_q;
        svc_d             = svc_q;
        pop               = 1'b0;
        ram_we            = 1'b0;
        ram_re            = 1'b0;
        rd_done           = 1'b0;
        wr_done           = 1'b0;
        memAccessResult   = '0;
        memAccessResponse = '0;
        unique case (state_q)
            MRS_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    svc_d     = fifo_q[rd_ptr_q[PTR_W-1:0]];
                    lat_cnt_d = lat_t'(MEM_LATENCY - 1);
                    state_d   = MRS_WAIT;
                end
            end
            MRS_WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - lat_t'(1);
                end else begin
                    ram_we  = svc_q.we;
                    ram_re  = !svc_q.we;
                    state_d = MRS_RESPOND;
                end
            end
            MRS_RESPOND: begin
                if (svc_q.we) begin
                    wr_done                  = 1'b1;
                    memAccessResponse.valid  = 1'b1;
                    memAccessResponse.serial = svc_q.wserial;
                end else begin
                    rd_done                = 1'b1;
                    memAccessResult.valid  = 1'b1;
                    memAccessResult.serial = svc_q.serial;
                    memAccessResult.data   = ram_rdata;
                end
                state_d = MRS_IDLE;
            end
            default: state_d = MRS_IDLE;
        endcase
    end

    // Counters drop in the cycle the completion pulses; inc+dec together cancel out.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + ptr_t'(push);
        rd_ptr_d    = rd_ptr_q + ptr_t'(pop);
        rd_serial_d = rd_serial_q;
        wr_serial_d = wr_serial_q;
        rd_out_d    = rd_out_q;
        wr_out_d    = wr_out_q;
        if (push && !memAccessReq.we) begin
            rd_serial_d = next_rd_serial(rd_serial_q);
        end
        if (push && memAccessReq.we) begin
            wr_serial_d = next_wr_serial(wr_serial_q);
        end
        case ({push && !memAccessReq.we, rd_done})
            2'b10:   rd_out_d = rd_out_q + OutstandingCount'(1);
            2'b01:   rd_out_d = rd_out_q - OutstandingCount'(1);
            default: rd_out_d = rd_out_q;
        endcase
        case ({push && memAccessReq.we, wr_done})
            2'b10:   wr_out_d = wr_out_q + OutstandingCount'(1);
            2'b01:   wr_out_d = wr_out_q - OutstandingCount'(1);
            default: wr_out_d = wr_out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MRS_IDLE;
            lat_cnt_q   <= '0;
            svc_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_out_q    <= '0;
            wr_out_q    <= '0;
            rd_serial_q <= '0;
            wr_serial_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            svc_q       <= svc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_out_q    <= rd_out_d;
            wr_out_q    <= wr_out_d;
            rd_serial_q <= rd_serial_d;
            wr_serial_q <= wr_serial_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
        end
    end

    // Offset and upper address bits alias onto the same line by design.
    assign ram_index        = svc_q.addr[ADDR_LO +: MEM_INDEX_BIT_WIDTH];
    assign unused_addr_bits = ^{svc_q.addr[PHY_ADDR_WIDTH-1:ADDR_HI], svc_q.addr[ADDR_LO-1:0]};

    mem_access_line_ram #(
        .INDEX_W (MEM_INDEX_BIT_WIDTH),
        .DATA_W  (DCACHE_LINE_BIT_WIDTH)
    ) u_line_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_index),
        .wdata (svc_q.data),
        .re    (ram_re),
        .raddr (ram_index),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_access_responder.sv
// Bench for mem_access_responder: scenario tasks drive requests, a scoreboard queue
// holds the expected completions in request order and a monitor pops them.
module tb_mem_access_responder;
    import mem_access_responder_pkg::*;

    localparam int IDX_W = 9;
    localparam int LAT   = 4;
    localparam int EW    = 68; // {data_known, we, serial[1:0], data[63:0]}

    logic             clk = 1'b0;
    logic             rst;
    MemAccessReq      req;
    MemAccessReqAck   ack;
    MemAccessResult   res;
    MemAccessResponse rsp;

    mem_access_responder #(
        .MEM_LATENCY         (LAT),
        .QUEUE_DEPTH         (4),
        .MEM_INDEX_BIT_WIDTH (IDX_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .memAccessReq      (req),
        .memAccessReqAck   (ack),
        .memAccessResult   (res),
        .memAccessResponse (rsp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int              chk_cnt = 0;
    int              pass_cnt = 0;
    logic [EW-1:0]   exp_q[$];
    logic [63:0]     shadow[int];
    int              rd_ser_m = 0;
    int              wr_ser_m = 0;
    int              done_cnt = 0;
    int              last_done_cyc = -1;
    bit              last_was_write = 1'b0;
    logic [63:0]     last_rd_data = '0;
    int              last_ack_serial = 0;
    logic [EW-1:0]   mon_e;
    bit              mon_ok;

    // ---------------- monitor / scoreboard pop ----------------
    always @(negedge clk) begin
        if (!rst && (res.valid || rsp.valid)) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL completion_unexpected: cyc=%0d res.valid=%b rsp.valid=%b, required no completion",
                         cyc, res.valid, rsp.valid);
            end else begin
                mon_e = exp_q.pop_front();
                if (res.valid && rsp.valid) begin
                    mon_ok = 1'b0;
                end else if (res.valid) begin
                    mon_ok = !mon_e[66] && (res.serial === mon_e[65:64]) &&
                             (!mon_e[67] || res.data === mon_e[63:0]);
                end else begin
                    mon_ok = mon_e[66] && (MemAccessSerial'(rsp.serial) === mon_e[65:64]);
                end
                if (mon_ok) pass_cnt++;
                else $display("FAIL completion: cyc=%0d got res=%b/%0d/%h rsp=%b/%0d, required we=%b serial=%0d data=%h(known=%b)",
                              cyc, res.valid, res.serial, res.data, rsp.valid, rsp.serial,
                              mon_e[66], mon_e[65:64], mon_e[63:0], mon_e[67]);
            end
            done_cnt++;
            last_done_cyc  = cyc;
            last_was_write = rsp.valid;
            if (res.valid) last_rd_data = res.data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
        req.valid = 1'b0;
    endtask

    task automatic drive_cycle(input bit we, input logic [31:0] addr, input logic [63:0] data,
                               output bit acked);
        int idx;
        bit known;
        @(negedge clk);
        #1;
        req.valid = 1'b1;
        req.we    = we;
        req.addr  = addr;
        req.data  = data;
        #1;
        acked = ack.ack;
        idx   = int'((addr >> 3) & 32'h1FF);
        if (acked) begin
            chk_cnt++;
            if (we) begin
                last_ack_serial = int'(ack.wserial);
                if (ack.wserial === MemWriteSerial'(wr_ser_m) && ack.serial === '0) pass_cnt++;
                else $display("FAIL ack_wserial: got wserial=%0d serial=%0d, required wserial=%0d serial=0",
                              ack.wserial, ack.serial, wr_ser_m);
                exp_q.push_back({1'b0, 1'b1, MemAccessSerial'(wr_ser_m), 64'h0});
                wr_ser_m = (wr_ser_m + 1) % MSHR_NUM;
                shadow[idx] = data;
            end else begin
                last_ack_serial = int'(ack.serial);
                if (ack.serial === MemAccessSerial'(rd_ser_m) && ack.wserial === '0) pass_cnt++;
                else $display("FAIL ack_serial: got serial=%0d wserial=%0d, required serial=%0d wserial=0",
                              ack.serial, ack.wserial, rd_ser_m);
                known = (shadow.exists(idx) != 0);
                exp_q.push_back({known, 1'b0, MemAccessSerial'(rd_ser_m), known ? shadow[idx] : 64'h0});
                rd_ser_m = (rd_ser_m + 1) % (MSHR_NUM + 1);
            end
        end
    endtask

    task automatic send_req(input bit we, input logic [31:0] addr, input logic [63:0] data,
                            input int budget, output int ack_cyc);
        bit acked = 1'b0;
        int k = 0;
        ack_cyc = -1;
        while (!acked && k < budget) begin
            drive_cycle(we, addr, data, acked);
            k++;
        end
        if (acked) ack_cyc = cyc;
        else begin
            chk_cnt++;
            $display("FAIL send_timeout: addr=%h not acked within %0d cycles, required ack", addr, budget);
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt <= n && k < budget) begin
            step();
            k++;
        end
        if (done_cnt <= n) begin
            chk_cnt++;
            $display("FAIL done_timeout: completions=%0d after %0d cycles, required >%0d", done_cnt, budget, n);
        end
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        chk_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: %0d completions still pending, required 0", exp_q.size());
    endtask

    task automatic apply_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        rd_ser_m = 0;
        wr_ser_m = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit acked;
        rst = 1'b1;
        req = '0;
        repeat (3) step();
        chk_cnt += 3;
        if (ack.ack === 1'b0) pass_cnt++;
        else $display("FAIL reset_ack: got %b, required 0", ack.ack);
        if (res.valid === 1'b0) pass_cnt++;
        else $display("FAIL reset_result_valid: got %b, required 0", res.valid);
        if (rsp.valid === 1'b0) pass_cnt++;
        else $display("FAIL reset_response_valid: got %b, required 0", rsp.valid);
        rst = 1'b0;
        step();
        chk_cnt += 2;
        if (res.valid === 1'b0 && rsp.valid === 1'b0) pass_cnt++;
        else $display("FAIL post_reset_idle: got res=%b rsp=%b, required 0/0", res.valid, rsp.valid);
        drive_cycle(1'b0, 32'h0000_0040, 64'h0, acked);
        if (acked === 1'b1) pass_cnt++;
        else $display("FAIL post_reset_first_ack: got %b, required 1", acked);
        wait_drain(20);
    endtask

    task automatic test_write_read();
        int t;
        int n;
        apply_reset();
        n = done_cnt;
        send_req(1'b1, 32'h100, 64'h1122334455667788, 4, t);
        wait_done(n, 12);
        chk_cnt++;
        if (last_done_cyc == t + LAT + 2 && last_was_write) pass_cnt++;
        else $display("FAIL write_latency: got cyc=%0d write=%b, required cyc=%0d write=1",
                      last_done_cyc, last_was_write, t + LAT + 2);
        n = done_cnt;
        send_req(1'b0, 32'h100, 64'h0, 4, t);
        wait_done(n, 12);
        chk_cnt += 2;
        if (last_done_cyc == t + LAT + 2 && !last_was_write) pass_cnt++;
        else $display("FAIL read_latency: got cyc=%0d, required %0d", last_done_cyc, t + LAT + 2);
        if (last_rd_data === 64'h1122334455667788) pass_cnt++;
        else $display("FAIL read_after_write: got %h, required 1122334455667788", last_rd_data);
    endtask

    task automatic test_read_burst();
        bit exp_ack[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bit acked;
        int n;
        int t;
        apply_reset();
        n = done_cnt;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 32'h100, 64'h0, acked);
            chk_cnt++;
            if (acked === exp_ack[i]) pass_cnt++;
            else $display("FAIL burst_ack%0d: got %b, required %b", i, acked, exp_ack[i]);
        end
        send_req(1'b0, 32'h100, 64'h0, 12, t);
        chk_cnt++;
        if (done_cnt == n + 1 && t == last_done_cyc + 1) pass_cnt++;
        else $display("FAIL burst_retry_ack: got ack cyc=%0d completions=%0d, required cyc=%0d completions=1",
                      t, done_cnt - n, last_done_cyc + 1);
        wait_drain(40);
    endtask

    task automatic test_serial_wrap();
        int exp_ser[6] = '{0, 1, 2, 0, 1, 2};
        int t;
        int n;
        logic [31:0] a;
        apply_reset();
        n = done_cnt;
        for (int i = 0; i < 6; i++) begin
            a = (i % 2 == 0) ? 32'h100 : {20'h0, 9'($urandom_range(0, 511)), 3'b000};
            send_req(1'b0, a, 64'h0, 20, t);
            chk_cnt++;
            if (last_ack_serial == exp_ser[i]) pass_cnt++;
            else $display("FAIL serial_wrap%0d: got %0d, required %0d", i, last_ack_serial, exp_ser[i]);
            repeat ($urandom_range(0, 8)) step();
        end
        wait_drain(60);
        chk_cnt++;
        if (done_cnt == n + 6) pass_cnt++;
        else $display("FAIL serial_wrap_count: got %0d completions, required 6", done_cnt - n);
    endtask

    task automatic test_back_to_back_writes();
        bit exp_ack[3] = '{1'b1, 1'b1, 1'b0};
        int exp_ws[2] = '{0, 1};
        logic [31:0] addrs[3] = '{32'h300, 32'h308, 32'h310};
        logic [63:0] datas[3];
        bit acked;
        int t;
        apply_reset();
        for (int i = 0; i < 3; i++) datas[i] = {$urandom(), $urandom()};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, addrs[i], datas[i], acked);
            chk_cnt++;
            if (acked === exp_ack[i]) pass_cnt++;
            else $display("FAIL wr_burst_ack%0d: got %b, required %b", i, acked, exp_ack[i]);
            if (i < 2) begin
                chk_cnt++;
                if (last_ack_serial == exp_ws[i]) pass_cnt++;
                else $display("FAIL wr_burst_wserial%0d: got %0d, required %0d", i, last_ack_serial, exp_ws[i]);
            end
        end
        send_req(1'b1, addrs[2], datas[2], 12, t);
        chk_cnt += 2;
        if (t == last_done_cyc + 1 && last_was_write) pass_cnt++;
        else $display("FAIL wr_retry_ack: got cyc=%0d, required %0d after first response", t, last_done_cyc + 1);
        if (last_ack_serial == 0) pass_cnt++;
        else $display("FAIL wr_retry_wserial: got %0d, required 0", last_ack_serial);
        for (int i = 0; i < 3; i++) send_req(1'b0, addrs[i], 64'h0, 20, t);
        wait_drain(60);
    endtask

    task automatic test_reset_mid();
        int t;
        int n;
        apply_reset();
        send_req(1'b0, 32'h100, 64'h0, 4, t);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        rd_ser_m = 0;
        wr_ser_m = 0;
        n = done_cnt;
        repeat (12) step();
        chk_cnt++;
        if (done_cnt == n) pass_cnt++;
        else $display("FAIL reset_drop: got %0d completions after reset, required 0", done_cnt - n);
        send_req(1'b0, 32'h100, 64'h0, 4, t);
        chk_cnt++;
        if (last_ack_serial == 0) pass_cnt++;
        else $display("FAIL reset_serial: got %0d, required 0", last_ack_serial);
        wait_done(n, 12);
        chk_cnt++;
        if (last_done_cyc == t + LAT + 2) pass_cnt++;
        else $display("FAIL reset_latency: got cyc=%0d, required %0d", last_done_cyc, t + LAT + 2);
    endtask

    task automatic test_alias();
        int t;
        int n;
        logic [63:0] da;
        logic [63:0] db;
        apply_reset();
        da = 64'hA5A5_0102_0304_5A5A;
        db = 64'h0BAD_F00D_CAFE_BEEF;
        send_req(1'b1, 32'h200, da, 4, t);
        n = done_cnt;
        send_req(1'b0, 32'h1200, 64'h0, 12, t);
        wait_done(n + 1, 20);
        chk_cnt++;
        if (last_rd_data === da) pass_cnt++;
        else $display("FAIL alias_upper: got %h, required %h", last_rd_data, da);
        n = done_cnt;
        send_req(1'b0, 32'h204, 64'h0, 12, t);
        wait_done(n, 20);
        chk_cnt++;
        if (last_rd_data === da) pass_cnt++;
        else $display("FAIL alias_offset: got %h, required %h", last_rd_data, da);
        send_req(1'b1, 32'h1208, db, 12, t);
        n = done_cnt;
        send_req(1'b0, 32'h200, 64'h0, 12, t);
        wait_done(n + 1, 20);
        chk_cnt++;
        if (last_rd_data === da) pass_cnt++;
        else $display("FAIL alias_neighbour: got %h, required %h", last_rd_data, da);
        wait_drain(20);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        test_reset();
        test_write_read();
        test_read_burst();
        test_serial_wrap();
        test_back_to_back_writes();
        test_reset_mid();
        test_alias();
        repeat (2) step();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
        $fatal(1, "watchdog");
    end

endmodule
